aes128_enc_iter: RTL and testbench
==================================

Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly from the cipher key.
- It is the transmit-side counterpart of the team's inverse-cipher datapath and produces the ciphertext that the decryptor consumes.
- Uses a start/done handshake towards the controlling FSM.
- Byte order follows FIPS-197: state byte 0 is [127:120], column-major.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is a configuration error (elaboration assertion).
- HOLD_OUT, 1, behaviour of data_out after completion:
  - 1: data_out holds until the next completion.
  - 0: data_out returns to 0 on the cycle after done.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request to encrypt. Sampled only while busy=0.
- key_in, input, 128, cipher key. Captured on the accepting edge.
- data_in, input, 128, plaintext block. Captured on the accepting edge.
- data_out, output, 128, ciphertext. Valid when done=1.
- done, output, 1, single-cycle completion pulse.
- busy, output, 1, high while an encryption is in progress.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, round counter=0, internal state/key registers=0.
  - data_out=0, done=0, busy=0.
  - rst dominates start.
- FSM states: IDLE, ROUND.
- IDLE:
  - On an edge with start=1: st <= data_in ^ key_in; rk <= key_in; rnd <= 1; busy <= 1; state <= ROUND.
- ROUND, every edge:
  - rk_next = KeyExpand(rk, rcon[rnd]).
  - KeyExpand: w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - rcon sequence for rnd 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - rnd<10: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_next; rk <= rk_next; rnd <= rnd+1.
  - rnd==10: data_out <= ShiftRows(SubBytes(st)) ^ rk_next (no MixColumns); done <= 1; busy <= 0; rnd <= 0; state <= IDLE.
- Latency:
  - done rises exactly NR=10 clock edges after the accepting edge.
  - busy is high for exactly 10 cycles.
  - Throughput is one block per 11 cycles, because start is accepted again on the cycle in which done is high.
- done is high for exactly one cycle. It is not reasserted unless a new block completes.
- start while busy=1 is ignored: no queueing, no effect on the in-flight block. key_in/data_in changes while busy have no effect.
- start held high continuously: a new block is accepted on every edge where busy=0, including the done cycle.
- Reset mid-operation: the block is abandoned, no done pulse, all outputs at reset values on the next cycle.
- Arithmetic:
  - All XORs are 128-bit.
  - MixColumns is over GF(2^8) with polynomial 0x11b; xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0).
- S-boxes: 20 combinational S-box instances (16 for state, 4 for key SubWord). No multi-cycle lookups.

Optional Feature:
- Macro: AES128_ENC_LASTKEY_EN.
- Defined:
  - Extra output port last_key [127:0], set to 0 on reset.
  - Loaded with rk_next on the rnd==10 edge, i.e. the final round key, simultaneously with done.
  - Holds until the next completion, regardless of HOLD_OUT.
  - Lets the decryptor start its inverse key schedule without a stored key table.
- Undefined:
  - The port does not exist.
  - The final round key is discarded when returning to IDLE.
  - Behaviour is otherwise identical.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key_in=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff, 1-cycle start.
  - Expect: done at edge +10 with data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
  - With AES128_ENC_LASTKEY_EN: last_key=13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
  - Expect: data_out=3925841d02dc09fbdc118597196a0b32. busy high for exactly 10 cycles. done is a 1-cycle pulse.
- Back-to-back:
  - Stimulus: hold start=1 over both vectors, switching data_in/key_in on the done cycle.
  - Expect: second done exactly 11 cycles after the first, with the correct ciphertext.
- Ignored start:
  - Stimulus: start C.1, then pulse start with the Appendix B vector at edge +4.
  - Expect: the single done at +10 carries the C.1 ciphertext. No second done follows.
- Reset mid-op:
  - Stimulus: start C.1, assert rst at edge +5 for 1 cycle.
  - Expect: busy=0, done=0, data_out=0 next cycle, and no done for 20 further cycles. A fresh start then yields the correct result.
- HOLD_OUT=0:
  - Expect: data_out=69c4...c55a only during the done cycle, and 0 on the following cycle.

Source files
------------

// File: rtl/aes128_enc_iter_if.sv
// aes128_enc_iter_if: start/done handshake and data bus of the iterative AES-128 encryptor
// master: controller side (drives start, key_in, data_in)
// slave:  core side (drives data_out, done, busy)
interface aes128_enc_iter_if;
  logic start;
  logic [127:0] key_in;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic done;
  logic busy;
  modport master(output start, key_in, data_in, input data_out, done, busy);
  modport slave(input start, key_in, data_in, output data_out, done, busy);
endinterface

// File: rtl/aes128_enc_iter.sv
// aes128_enc_iter: iterative AES-128 encryptor, one round per clock, round keys expanded on the fly
// Ports: clk, rst (sync active-high), bus (aes128_enc_iter_if.slave: start/key_in/data_in in,
//   data_out/done/busy out). With AES128_ENC_LASTKEY_EN defined an extra output last_key
//   carries the final round key, loaded together with done.
// Byte 0 of every 128-bit word is [127:120], column-major.
module aes128_enc_iter #(
  parameter int NR = 10,
  parameter bit HOLD_OUT = 1'b1
) (
  input logic clk,
  input logic rst,
  aes128_enc_iter_if.slave bus
`ifdef AES128_ENC_LASTKEY_EN
  , output logic [127:0] last_key
`endif
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [0:15][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
    8'h40, 8'h80, 8'h1b, 8'h36, 40'h0};
  if (NR != 10) begin : g_nr_check
    $error("aes128_enc_iter: NR must be 10 for AES-128");
  end
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  typedef enum logic {IDLE, ROUND} state_t;
  state_t state, state_n;
  logic [127:0] st, rk, rk_next, sr, mc, dout;
  logic [31:0] sw, k0, k1, k2, k3;
  logic [7:0] sb [16];
  logic [3:0] rnd;
  logic done_q, last;
  assign last = rnd == 4'(NR);
  // SubBytes then ShiftRows: output (row r, col c) takes input (row r, col (c+r)%4)
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign sb[i] = sbox(st[127-8*i -: 8]);
    assign sr[127-8*i -: 8] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
  end
  for (genvar c = 0; c < 4; c++) begin : g_mc
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = sr[127-32*c -: 32];
    assign mc[127-32*c -: 32] = {
      xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
      xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  end
  // SubWord(RotWord(w3)) ^ rcon, then the running XOR chain across the four words
  assign sw = {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])} ^ {RCON[rnd], 24'h0};
  assign k0 = rk[127:96] ^ sw;
  assign k1 = rk[95:64] ^ k0;
  assign k2 = rk[63:32] ^ k1;
  assign k3 = rk[31:0] ^ k2;
  assign rk_next = {k0, k1, k2, k3};
  always_comb state_n = (state == IDLE) ? (bus.start ? ROUND : IDLE) : (last ? IDLE : ROUND);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rnd <= '0;
      st <= '0;
      rk <= '0;
      dout <= '0;
      done_q <= 1'b0;
`ifdef AES128_ENC_LASTKEY_EN
      last_key <= '0;
`endif
    end else begin
      state <= state_n;
      done_q <= 1'b0;
      if (!HOLD_OUT) dout <= '0;
      if (state == IDLE) begin
        if (bus.start) begin
          st <= bus.data_in ^ bus.key_in;
          rk <= bus.key_in;
          rnd <= 4'd1;
        end
      end else if (last) begin
        dout <= sr ^ rk_next;
        done_q <= 1'b1;
        rnd <= '0;
`ifdef AES128_ENC_LASTKEY_EN
        last_key <= rk_next;
`endif
      end else begin
        st <= mc ^ rk_next;
        rk <= rk_next;
        rnd <= rnd + 4'd1;
      end
    end
  end
  assign bus.data_out = dout;
  assign bus.done = done_q;
  assign bus.busy = state == ROUND;
endmodule

// File: tb/tb_aes128_enc_iter.sv
// tb_aes128_enc_iter: scoreboard bench for aes128_enc_iter against a byte-level AES reference model
module tb_aes128_enc_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  aes128_enc_iter_if bus();
  aes128_enc_iter_if bus0();
  assign bus0.start = bus.start;
  assign bus0.key_in = bus.key_in;
  assign bus0.data_in = bus.data_in;
`ifdef AES128_ENC_LASTKEY_EN
  logic [127:0] lk, lk0;
`endif
  aes128_enc_iter dut (.clk(clk), .rst(rst), .bus(bus)
`ifdef AES128_ENC_LASTKEY_EN
    , .last_key(lk)
`endif
  );
  aes128_enc_iter #(.HOLD_OUT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0)
`ifdef AES128_ENC_LASTKEY_EN
    , .last_key(lk0)
`endif
  );
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_LK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT = 128'h3925841d02dc09fbdc118597196a0b32;
  typedef struct {
    logic [127:0] ct;
    logic [127:0] lk;
    int due;
  } exp_t;
  exp_t q[$];
  logic [7:0] sbt [256];
  int n_chk = 0, n_fail = 0, edge_n = 0;
  logic m_busy = 1'b0, m_done = 1'b0;
  logic [127:0] m_hold = '0, m_lk = '0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x} << n;
    return d[15:8];
  endfunction
  function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] pt,
                                      output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc, m, coef;
    logic [31:0] x;
    logic [127:0] out;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]], sbt[x[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[(i % 4) + 4 * ((i / 4 + 4 - i % 4) % 4)] = sbt[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          m = 8'h00;
          for (int k = 0; k < 4; k++) begin
            coef = ((k - row + 4) % 4 == 0) ? 8'h02 : ((k - row + 4) % 4 == 1) ? 8'h03 : 8'h01;
            m ^= gmul(coef, t[k+4*c]);
          end
          s[row+4*c] = (r == 10 ? t[row+4*c] : m) ^ w[4*r+c][31-8*row -: 8];
        end
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
    return out;
  endfunction
  always @(posedge clk) begin
    exp_t e;
    logic acc;
    edge_n++;
    if (rst) begin
      q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hold = '0;
      m_lk = '0;
    end else begin
      acc = !m_busy && bus.start;
      m_done = q.size() > 0 && q[0].due == edge_n;
      if (m_done) begin
        m_hold = q[0].ct;
        m_lk = q[0].lk;
        m_busy = 1'b0;
      end
      if (acc) begin
        e.ct = aes(bus.key_in, bus.data_in, e.lk);
        e.due = edge_n + 10;
        q.push_back(e);
        m_busy = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    chk("busy", {127'h0, bus.busy}, {127'h0, m_busy});
    chk("done", {127'h0, bus.done}, {127'h0, m_done});
    chk("data_out_hold", bus.data_out, m_hold);
    chk("busy_h0", {127'h0, bus0.busy}, {127'h0, m_busy});
    chk("done_h0", {127'h0, bus0.done}, {127'h0, m_done});
    chk("data_out_h0", bus0.data_out, m_done ? m_hold : 128'h0);
`ifdef AES128_ENC_LASTKEY_EN
    chk("last_key", lk, m_lk);
    chk("last_key_h0", lk0, m_lk);
`endif
    if (m_done && q.size() > 0) begin
      e = q.pop_front();
      chk("scoreboard_ct", bus.data_out, e.ct);
    end
  end
  task automatic send(input logic [127:0] key, input logic [127:0] pt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key_in = key;
    bus.data_in = pt;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.data_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(C1_KEY, C1_PT);
    repeat (10) @(negedge clk);
    chk("c1_done", {127'h0, bus.done}, 128'h1);
    chk("c1_ct", bus.data_out, C1_CT);
`ifdef AES128_ENC_LASTKEY_EN
    chk("c1_last_key", lk, C1_LK);
`endif
    repeat (2) @(negedge clk);
    send(B_KEY, B_PT);
    repeat (10) @(negedge clk);
    chk("b_ct", bus.data_out, B_CT);
    repeat (2) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key_in = C1_KEY;
    bus.data_in = C1_PT;
    repeat (11) @(negedge clk);
    chk("b2b_first_ct", bus.data_out, C1_CT);
    bus.key_in = B_KEY;
    bus.data_in = B_PT;
    repeat (11) @(negedge clk);
    chk("b2b_second_done", {127'h0, bus.done}, 128'h1);
    chk("b2b_second_ct", bus.data_out, B_CT);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    send(C1_KEY, C1_PT);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.key_in = B_KEY;
    bus.data_in = B_PT;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored_start_ct", bus.data_out, C1_CT);
    repeat (15) @(negedge clk);
    send(C1_KEY, C1_PT);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {127'h0, bus.busy}, 128'h0);
    chk("rst_done", {127'h0, bus.done}, 128'h0);
    chk("rst_data_out", bus.data_out, 128'h0);
    repeat (20) @(negedge clk);
    send(C1_KEY, C1_PT);
    repeat (10) @(negedge clk);
    chk("after_rst_ct", bus.data_out, C1_CT);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = $urandom_range(0, 3) != 0;
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
      bus.data_in = {$urandom, $urandom, $urandom, $urandom};
      rst = $urandom_range(0, 199) == 0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
